// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM/blink stage.
// LED_PWM_GAMMA_EN selects squared (perceptual) duty mapping.
package led_pwm_pkg;

   localparam logic [1:0] REG_DUTY   = 2'd0;
   localparam logic [1:0] REG_BLINK  = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_PWM_EN   = 0;
   localparam int CTRL_BLINK_EN = 1;

   localparam logic [7:0] DUTY_RST = 8'hFF;
   localparam logic [7:0] LEDS_RST = 8'hFF;

   function automatic logic [7:0] duty_map(input logic [7:0] d);
`ifdef LED_PWM_GAMMA_EN
      logic [15:0] p;
      p = {8'h00, d} * {8'h00, d};
      return (d == 8'hFF) ? 8'hFF : p[15:8];
`else
      return d;
`endif
   endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Prescaler, PWM counter, shadowed duty and blink divider.
// Duty mapping follows LED_PWM_GAMMA_EN via led_pwm_pkg::duty_map.
module led_pwm_core
   import led_pwm_pkg::*;
#(
   parameter int PRESCALE = 16,
   parameter int BLINK_W  = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pwm_en,
   input  logic               blink_en,
   input  logic [7:0]         duty_reg,
   input  logic [BLINK_W-1:0] blink_div,
   input  logic               blink_wr,
   output logic               gate,
   output logic               frame_tick,
   output logic [7:0]         pwm_cnt,
   output logic               frame_active,
   output logic               blink_phase
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0]      presc;
   logic [7:0]         duty_act;
   logic [BLINK_W-1:0] frame_cnt;
   logic               tick;
   logic               pwm_en_q;
   logic               load;
   logic               pwm_on;

   assign tick       = (presc == PMAX);
   assign frame_tick = tick && (pwm_cnt == 8'hFF);
   assign load       = frame_tick || (pwm_en && !pwm_en_q);
   assign pwm_on     = (duty_act == 8'hFF) || (pwm_cnt < duty_act);

   assign frame_active = pwm_on;
   assign gate = (pwm_en ? pwm_on : 1'b1)
               & (blink_en ? blink_phase : 1'b1);

   // Counters free-run regardless of pwm_en.
   always_ff @(negedge clk) begin
      if (rst) begin
         presc    <= '0;
         pwm_cnt  <= '0;
         pwm_en_q <= 1'b0;
         duty_act <= duty_map(DUTY_RST);
      end else begin
         presc    <= tick ? '0 : presc + 1'b1;
         pwm_en_q <= pwm_en;
         if (tick)
            pwm_cnt <= pwm_cnt + 8'd1;
         if (load)
            duty_act <= duty_map(duty_reg);
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_div == '0) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_wr) begin
         frame_cnt <= '0;
      end else if (frame_tick) begin
         if (frame_cnt == blink_div - BLINK_W'(1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + BLINK_W'(1);
         end
      end
   end

endmodule

// File: rtl/mod_led_pwm.sv
// LED brightness/blink peripheral on the shared data bus.
// Optional gamma dimming: define LED_PWM_GAMMA_EN.
module mod_led_pwm
   import led_pwm_pkg::*;
#(
   parameter int PRESCALE = 16,
   parameter int BLINK_W  = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ie,
   input  logic        de,
   input  logic [31:0] iaddr,
   input  logic [31:0] daddr,
   input  logic [1:0]  drw,
   input  logic [31:0] din,
   output logic [31:0] iout,
   output logic [31:0] dout,
   input  logic [7:0]  leds_in,
   output logic [7:0]  leds_out
);

   logic [7:0]         duty_reg;
   logic [BLINK_W-1:0] blink_div;
   logic [1:0]         ctrl;
   logic [1:0]         sel;
   logic               wr;
   logic               blink_wr;
   logic               gate;
   logic               frame_tick;
   logic [7:0]         pwm_cnt;
   logic               frame_active;
   logic               blink_phase;
   logic               unused_ok;

   assign sel      = daddr[3:2];
   assign wr       = de && drw[0] && !rst;
   assign blink_wr = wr && (sel == REG_BLINK);
   assign iout     = '0;

   assign unused_ok = &{1'b0, ie, iaddr, daddr, drw[1], din, frame_tick};

   led_pwm_core #(
      .PRESCALE (PRESCALE),
      .BLINK_W  (BLINK_W)
   ) u_core (
      .clk          (clk),
      .rst          (rst),
      .pwm_en       (ctrl[CTRL_PWM_EN]),
      .blink_en     (ctrl[CTRL_BLINK_EN]),
      .duty_reg     (duty_reg),
      .blink_div    (blink_div),
      .blink_wr     (blink_wr),
      .gate         (gate),
      .frame_tick   (frame_tick),
      .pwm_cnt      (pwm_cnt),
      .frame_active (frame_active),
      .blink_phase  (blink_phase)
   );

   always_ff @(negedge clk) begin
      if (rst) begin
         duty_reg  <= DUTY_RST;
         blink_div <= '0;
         ctrl      <= '0;
         leds_out  <= LEDS_RST;
      end else begin
         leds_out <= leds_in & {8{gate}};
         if (wr) begin
            case (sel)
               REG_DUTY:  duty_reg  <= din[7:0];
               REG_BLINK: blink_div <= din[BLINK_W-1:0];
               REG_CTRL:  ctrl      <= din[1:0];
               default:   ;
            endcase
         end
      end
   end

   always_comb begin
      dout = '0;
      if (de) begin
         case (sel)
            REG_DUTY:  dout = {24'h0, duty_reg};
            REG_BLINK: dout = 32'(blink_div);
            REG_CTRL:  dout = {30'h0, ctrl};
            default:   dout = {22'h0, blink_phase, frame_active, pwm_cnt};
         endcase
      end
   end

endmodule

// File: tb/tb_mod_led_pwm.sv
// Directed bench for mod_led_pwm with PRESCALE=1 (256-clk frames).
// Expected on-counts switch with LED_PWM_GAMMA_EN.
module tb_mod_led_pwm;

`ifdef LED_PWM_GAMMA_EN
   localparam int ON40 = 16;
   localparam int ON80 = 64;
   localparam int ON10 = 1;
`else
   localparam int ON40 = 64;
   localparam int ON80 = 128;
   localparam int ON10 = 16;
`endif

   logic        clk;
   logic        rst;
   logic        ie;
   logic        de;
   logic [31:0] iaddr;
   logic [31:0] daddr;
   logic [1:0]  drw;
   logic [31:0] din;
   logic [31:0] iout;
   logic [31:0] dout;
   logic [7:0]  leds_in;
   logic [7:0]  leds_out;

   int ncmp = 0;
   int nfail = 0;
   logic [31:0] rd;

   mod_led_pwm #(
      .PRESCALE (1),
      .BLINK_W  (24)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ie       (ie),
      .de       (de),
      .iaddr    (iaddr),
      .daddr    (daddr),
      .drw      (drw),
      .din      (din),
      .iout     (iout),
      .dout     (dout),
      .leds_in  (leds_in),
      .leds_out (leds_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      ncmp++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s: got %h want %h", tag, o, e);
      end
   endtask

   task automatic rd_reg(input logic [1:0] idx, output logic [31:0] v);
      de    = 1'b1;
      drw   = 2'b10;
      daddr = {28'h0, idx, 2'b00};
      #1;
      v   = dout;
      de  = 1'b0;
      drw = 2'b00;
   endtask

   // Call right after a posedge; write lands on the following negedge.
   task automatic wr_reg(input logic [1:0] idx, input logic [31:0] v);
      de    = 1'b1;
      drw   = 2'b01;
      daddr = {28'h0, idx, 2'b00};
      din   = v;
      @(posedge clk);
      de  = 1'b0;
      drw = 2'b00;
   endtask

   // Stop at the posedge where pwm_cnt has just wrapped to 0.
   task automatic sync_frame(input string tag);
      logic [31:0] s;
      logic        found;
      found = 1'b0;
      for (int n = 0; n < 600 && !found; n++) begin
         @(posedge clk);
         rd_reg(2'd3, s);
         if (s[7:0] == 8'h00) found = 1'b1;
      end
      chk(tag, {31'h0, found}, 32'h1);
   endtask

   task automatic check_frames(input string tag, input int nfr,
                               input int on_a, input int on_b,
                               input logic [7:0] val, input int wr_at,
                               input logic [7:0] wr_dat);
      int bad;
      int first;
      int lim;
      logic [7:0] o;
      logic [7:0] e;
      logic [7:0] fo;
      logic [7:0] fe;
      bad = 0;
      first = -1;
      fo = '0;
      fe = '0;
      for (int i = 0; i < nfr * 256; i++) begin
         @(posedge clk);
         if (i == wr_at + 1) begin
            de  = 1'b0;
            drw = 2'b00;
         end
         lim = (i < 256) ? on_a : on_b;
         o = leds_out;
         e = ((i % 256) < lim) ? val : 8'h00;
         if (o !== e) begin
            bad++;
            if (first < 0) begin
               first = i;
               fo = o;
               fe = e;
            end
         end
         if (i == wr_at) begin
            de    = 1'b1;
            drw   = 2'b01;
            daddr = 32'h0;
            din   = {24'h0, wr_dat};
         end
      end
      ncmp++;
      assert (bad == 0) else begin
         nfail++;
         $error("FAIL %s: %0d bad samples, first at %0d got %h want %h",
                tag, bad, first, fo, fe);
      end
   endtask

   initial begin
      rst     = 1'b1;
      ie      = 1'b0;
      de      = 1'b0;
      iaddr   = '0;
      daddr   = '0;
      drw     = 2'b00;
      din     = '0;
      leds_in = 8'h00;

      // Write attempted under reset must be dropped.
      @(posedge clk);
      de    = 1'b1;
      drw   = 2'b01;
      daddr = 32'h0;
      din   = 32'h12;
      @(posedge clk);
      de  = 1'b0;
      drw = 2'b00;
      @(posedge clk);

      chk("rst_leds", {24'h0, leds_out}, 32'hFF);
      rd_reg(2'd0, rd);
      chk("rst_duty", rd, 32'hFF);
      rd_reg(2'd2, rd);
      chk("rst_ctrl", rd, 32'h0);
      rd_reg(2'd1, rd);
      chk("rst_blink", rd, 32'h0);
      rd_reg(2'd3, rd);
      chk("rst_status", rd, 32'h300);
      rst = 1'b0;

      @(posedge clk);
      chk("pass_00", {24'h0, leds_out}, 32'h00);
      leds_in = 8'hA5;
      @(posedge clk);
      chk("pass_a5", {24'h0, leds_out}, 32'hA5);
      de = 1'b0;
      #1;
      chk("dout_idle", dout, 32'h0);
      chk("iout", iout, 32'h0);

      wr_reg(2'd2, 32'hFFFF_FFFC);
      rd_reg(2'd2, rd);
      chk("ctrl_upper", rd, 32'h0);
      wr_reg(2'd3, 32'hFFFF_FFFF);
      rd_reg(2'd0, rd);
      chk("status_ro", rd, 32'hFF);
      wr_reg(2'd1, 32'hFFFF_FFFF);
      rd_reg(2'd1, rd);
      chk("blink_w", rd, 32'h00FF_FFFF);
      wr_reg(2'd1, 32'h0);

      leds_in = 8'hFF;
      wr_reg(2'd0, 32'h40);
      wr_reg(2'd2, 32'h1);
      sync_frame("sync40");
      check_frames("duty40", 1, ON40, 0, 8'hFF, -1, 8'h00);

      wr_reg(2'd0, 32'h00);
      sync_frame("sync00");
      check_frames("duty00", 1, 0, 0, 8'hFF, -1, 8'h00);

      wr_reg(2'd0, 32'hFF);
      sync_frame("syncff");
      check_frames("dutyff", 1, 256, 0, 8'hFF, -1, 8'h00);

      wr_reg(2'd0, 32'h80);
      rd_reg(2'd0, rd);
      chk("rd_80", rd, 32'h80);
      sync_frame("sync80");
      check_frames("midframe", 2, ON80, ON10, 8'hFF, 4, 8'h10);
      rd_reg(2'd0, rd);
      chk("rd_10", rd, 32'h10);

      leds_in = 8'h0F;
      sync_frame("syncbl0");
      wr_reg(2'd1, 32'h2);
      wr_reg(2'd2, 32'h2);
      sync_frame("syncbl1");
      check_frames("blink_a", 1, 256, 0, 8'h0F, -1, 8'h00);
      check_frames("blink_b", 2, 0, 0, 8'h0F, -1, 8'h00);
      check_frames("blink_c", 1, 256, 0, 8'h0F, -1, 8'h00);

      wr_reg(2'd1, 32'h0);
      sync_frame("syncdiv0");
      check_frames("blink_div0", 1, 256, 0, 8'h0F, -1, 8'h00);

      wr_reg(2'd2, 32'h0);
      leds_in = 8'h3C;
      @(posedge clk);
      chk("pass_3c", {24'h0, leds_out}, 32'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/mod_led_pwm.md
Name: mod_led_pwm

Overview:
- Memory-mapped LED brightness/blink stage directly downstream of the LED register peripheral.
- Consumes its 8-bit leds vector; drives the board LED pins.
- Applies global PWM dimming and optional blinking.
- Attaches to the same ie/de/iaddr/daddr/drw/din/iout/dout data bus as every other mod_* peripheral.

Parameters:
- PRESCALE, 16, clk cycles per PWM tick (min 1); PWM frame = 256 ticks.
- BLINK_W, 24, width of the blink divider register (max 32).

Ports:
- clk  input  1  system clock; all logic on falling edge (bus convention).
- rst  input  1  synchronous active-high reset, sampled on the falling edge of clk.
- ie  input  1  instruction enable; unused.
- de  input  1  data enable for this module.
- iaddr  input  32  instruction address; unused.
- daddr  input  32  data address; daddr[3:2] selects the register.
- drw  input  2  bit0 = write, bit1 = read.
- din  input  32  write data.
- iout  output  32  constant 0.
- dout  output  32  read data (combinational).
- leds_in  input  8  LED vector from the LED register peripheral.
- leds_out  output  8  registered drive to the board LED pins.

Behaviour:
- Registers (daddr[3:2]):
  - 0 DUTY: 8b, reset 0xFF.
  - 1 BLINK_DIV: BLINK_W bits, reset 0.
  - 2 CTRL: bit0 pwm_en, bit1 blink_en; reset 0.
  - 3 STATUS: read-only, {22'b0, blink_phase, frame_active, pwm_cnt[7:0]}.
- Write: de && drw[0] && !rst on falling edge; takes din low bits; writes to STATUS are ignored; upper din bits are ignored.
- Read: dout = selected register, zero-extended; dout = 0 when !de.
- Prescaler:
  - Counts 0..PRESCALE-1 and emits a tick on PRESCALE-1.
  - pwm_cnt (8b) increments on each tick and wraps 255->0.
  - The wrap is the frame boundary.
- Duty shadow:
  - The DUTY write lands in duty_reg immediately.
  - duty_act loads from duty_reg only at the frame boundary (glitch-free).
  - duty_act also loads on reset and on the cycle pwm_en goes 0->1.
- PWM on:
  - pwm_on = (duty_act == 0xFF) || (pwm_cnt < duty_act).
  - Duty 0 = always off; 0xFF = always on.
- Blink:
  - frame_cnt increments per frame boundary.
  - When frame_cnt == BLINK_DIV-1 at a boundary, blink_phase toggles and frame_cnt clears.
  - BLINK_DIV = 0 holds blink_phase = 1 with frame_cnt at 0.
  - Writing BLINK_DIV clears frame_cnt (phase unchanged).
- Gate: gate = (pwm_en ? pwm_on : 1) & (blink_en ? blink_phase : 1).
- Output: leds_out <= leds_in & {8{gate}}; one falling-edge latency from leds_in and from gate changes.
- frame_active (STATUS) = pwm_on.
- Reset (synchronous, same edge):
  - Clears prescaler, pwm_cnt and frame_cnt.
  - blink_phase = 1; leds_out = 8'hFF; registers take their reset values.
- Simultaneous events:
  - Reset wins over a write.
  - A DUTY write on a frame-boundary cycle: the new value goes to duty_reg; duty_act takes the OLD duty_reg that edge and the new one at the next boundary.
  - Disabling pwm_en mid-frame does not reset the counters; the counters always free-run.

Optional Feature:
- LED_PWM_GAMMA_EN:
  - Defined: the value loaded into duty_act is g = (duty_reg*duty_reg)>>8 (16b product, upper byte), except duty_reg = 0xFF maps to 0xFF. Perceptual dimming.
  - Undefined: duty_act = duty_reg unchanged.
  - Register readback always returns the raw duty_reg.

Decomposition:
- Package led_pwm_pkg:
  - Register index constants REG_DUTY=0, REG_BLINK=1, REG_CTRL=2, REG_STATUS=3.
  - CTRL bit positions CTRL_PWM_EN=0, CTRL_BLINK_EN=1.
  - Reset constants DUTY_RST=8'hFF, LEDS_RST=8'hFF.
- Sub-module led_pwm_core:
  - Contains the prescaler, pwm_cnt, duty shadow (plus gamma), frame_cnt and blink_phase.
  - Outputs gate, frame_tick and status bits.
- mod_led_pwm keeps the bus decode, registers and output register.

Test Plan:
- Reset and pass-through, PRESCALE=1: assert rst 2 cycles -> leds_out=0xFF, DUTY reads 0xFF, CTRL reads 0. Then leds_in=0xA5 -> leds_out=0xA5 on the next falling edge.
- PWM duty, PRESCALE=1: write DUTY=0x40, CTRL=1, leds_in=0xFF -> over each 256-cycle frame leds_out=0xFF for exactly 64 cycles, starting at pwm_cnt=0 of the next frame.
- Duty extremes: DUTY=0x00 -> leds_out=0x00 for a full frame. DUTY=0xFF -> 0xFF every cycle.
- Mid-frame duty write: DUTY=0x80, then write 0x10 at pwm_cnt=5 -> the current frame stays on 128 cycles; the next frame is on 16 cycles.
- Blink: BLINK_DIV=2, CTRL=2, leds_in=0x0F -> leds_out alternates 0x0F / 0x00 every 512 clk (PRESCALE=1). A BLINK_DIV=0 write -> steady 0x0F.
- Gamma build with LED_PWM_GAMMA_EN: DUTY=0x80 -> on 64 cycles per frame. DUTY=0xFF -> always on. DUTY readback = 0x80.
